// File: rtl/instr_issue.sv
// Fetch/issue sequencer: fetches 8-bit instructions from a synchronous-read imem,
// offers op/rs/rt/imm downstream on valid/ready and stalls after each branch.
module instr_issue #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            halt_req,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_rd,
  input  logic [7:0]      imem_rdata,
  output logic [1:0]      op,
  output logic [1:0]      rs,
  output logic [1:0]      rt,
  output logic [1:0]      imm,
  output logic            issue_valid,
  input  logic            issue_ready,
  input  logic            br_done,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  output logic [PC_W-1:0] pc,
  output logic            busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_ISSUE,
    ST_BR_WAIT
  } state_t;

  localparam logic [1:0] OP_BRANCH = 2'b11;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic [7:0]      ir, ir_nxt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its peers, regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      pc    <= RESET_PC;
      ir    <= 8'h00;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
    end
  end

  // NOTE: every signal written here gets a default first; a missed branch
  // would otherwise infer a latch.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    ir_nxt      = ir;
    imem_rd     = 1'b0;
    issue_valid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          pc_nxt    = RESET_PC;
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // Halt is checked before the read so a halted fetch leaves imem untouched.
        if (halt_req) begin
          state_nxt = ST_IDLE;
        end else begin
          imem_rd   = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        ir_nxt    = imem_rdata;
        state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        issue_valid = 1'b1;
        if (issue_ready) begin
          if (ir[7:6] == OP_BRANCH) begin
            state_nxt = ST_BR_WAIT;
          end else begin
            pc_nxt    = pc + PC_W'(1);
            state_nxt = ST_FETCH;
          end
        end
      end
      ST_BR_WAIT: begin
        if (br_done) begin
          pc_nxt    = br_taken ? br_target : pc + PC_W'(1);
          state_nxt = ST_FETCH;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign imem_addr = pc;
  assign op        = ir[7:6];
  assign rs        = ir[5:4];
  assign rt        = ir[3:2];
  assign imm       = ir[1:0];
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_instr_issue.sv
// Bench for instr_issue: imem model, directed scenarios and a randomized run
// checked against a program-walk reference model.
module tb_instr_issue;
  localparam int PC_W = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            halt_req = 1'b0;
  logic [PC_W-1:0] imem_addr;
  logic            imem_rd;
  logic [7:0]      imem_rdata = 8'h00;
  logic [1:0]      op, rs, rt, imm;
  logic            issue_valid;
  logic            issue_ready = 1'b0;
  logic            br_done = 1'b0;
  logic            br_taken = 1'b0;
  logic [PC_W-1:0] br_target = '0;
  logic [PC_W-1:0] pc;
  logic            busy;

  logic [7:0] mem [256];
  int checks = 0;
  int errors = 0;

  instr_issue #(.PC_W(PC_W), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_rdata(imem_rdata),
    .op(op), .rs(rs), .rt(rt), .imm(imm),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .br_done(br_done), .br_taken(br_taken), .br_target(br_target),
    .pc(pc), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory
  always @(posedge clk) if (imem_rd) imem_rdata <= mem[imem_addr];

  // Advance negedge by negedge until issue_valid shows, bounded by max cycles.
  // start and br_done are single-cycle pulses, dropped after the first edge.
  task automatic wait_valid(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      start   = 1'b0;
      br_done = 1'b0;
      n++;
    end while (issue_valid !== 1'b1 && n < max);
    checks++;
    if (issue_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_valid: issue_valid=%b after %0d cycles, required 1", issue_valid, n);
    end
  endtask

  task automatic go_idle();
    int n = 0;
    halt_req = 1'b1; issue_ready = 1'b1; br_done = 1'b1; br_taken = 1'b0;
    while (busy === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL go_idle: busy=%b, required 0", busy);
    end
    halt_req = 1'b0; issue_ready = 1'b0; br_done = 1'b0;
  endtask

  // Start from RESET_PC and run straight-line code up to the branch at pc 4,
  // leaving it held in ISSUE with ready low.
  task automatic run_to_pc4();
    int n;
    mem[0] = 8'h1B; mem[1] = 8'h46; mem[2] = 8'h87; mem[3] = 8'h1B; mem[4] = 8'hC0;
    issue_ready = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_valid(10, n);
      if (pc === 8'h04) break;
    end
    issue_ready = 1'b0;
    checks++;
    if (pc !== 8'h04 || {op, rs, rt, imm} !== 8'hC0) begin
      errors++;
      $display("FAIL run_to_pc4: pc=%h instr=%h, required pc=04 instr=c0", pc, {op, rs, rt, imm});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, issue_valid, imem_rd} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: busy/valid/rd=%b, required 000", {busy, issue_valid, imem_rd});
    end
    checks++;
    if (pc !== 8'h00 || imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_pc: pc=%h addr=%h, required 00", pc, imem_addr);
    end
    checks++;
    if ({op, rs, rt, imm} !== 8'h00) begin
      errors++;
      $display("FAIL reset_fields: %h, required 00", {op, rs, rt, imm});
    end
    rst_n = 1'b1;
    br_done = 1'b1; issue_ready = 1'b1;
    @(negedge clk);
    br_done = 1'b0; issue_ready = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: busy=%b without start, required 0", busy);
    end
  endtask

  // Three straight-line ops, ready held high, halt raised on the last one.
  task automatic test_sequence_and_halt();
    logic [7:0] exp [3];
    int n;
    exp[0] = 8'h1B; exp[1] = 8'h46; exp[2] = 8'h87;
    for (int i = 0; i < 3; i++) mem[i] = exp[i];
    issue_ready = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_valid(10, n);
      checks++;
      if (n !== 3) begin
        errors++;
        $display("FAIL issue_latency[%0d]: %0d cycles, required 3", i, n);
      end
      checks++;
      if ({op, rs, rt, imm} !== exp[i] || pc !== PC_W'(i)) begin
        errors++;
        $display("FAIL issue_fields[%0d]: instr=%h pc=%h, required %h pc=%h",
                 i, {op, rs, rt, imm}, pc, exp[i], PC_W'(i));
      end
    end
    halt_req = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_rd !== 1'b0 || pc !== 8'h03) begin
      errors++;
      $display("FAIL halt_fetch: imem_rd=%b pc=%h, required 0 pc=03", imem_rd, pc);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_idle: busy=%b valid=%b, required 0 0", busy, issue_valid);
    end
    halt_req = 1'b0; issue_ready = 1'b0;
  endtask

  task automatic test_stall();
    int n;
    mem[0] = 8'h6D;
    issue_ready = 1'b0;
    start = 1'b1;
    wait_valid(10, n);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (issue_valid !== 1'b1 || {op, rs, rt, imm} !== 8'h6D || pc !== 8'h00) begin
        errors++;
        $display("FAIL stall_hold[%0d]: valid=%b instr=%h pc=%h, required 1 6d 00",
                 k, issue_valid, {op, rs, rt, imm}, pc);
      end
      if (k < 5) @(negedge clk);
    end
    issue_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (issue_valid !== 1'b0 || pc !== 8'h01) begin
      errors++;
      $display("FAIL stall_accept: valid=%b pc=%h, required 0 01", issue_valid, pc);
    end
    go_idle();
  endtask

  task automatic test_branch_and_wrap();
    int n;
    run_to_pc4();
    br_done = 1'b1; br_taken = 1'b1; br_target = 8'h77;
    @(negedge clk);
    br_done = 1'b0;
    checks++;
    if (issue_valid !== 1'b1 || pc !== 8'h04) begin
      errors++;
      $display("FAIL br_done_ignored: valid=%b pc=%h, required 1 04", issue_valid, pc);
    end
    issue_ready = 1'b1;
    @(negedge clk);
    issue_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({issue_valid, busy, imem_rd} !== 3'b010 || pc !== 8'h04) begin
        errors++;
        $display("FAIL br_wait[%0d]: valid/busy/rd=%b pc=%h, required 010 04",
                 k, {issue_valid, busy, imem_rd}, pc);
      end
      @(negedge clk);
    end
    mem[8'h20] = 8'hC0; mem[8'hFF] = 8'h46;
    br_done = 1'b1; br_taken = 1'b1; br_target = 8'h20;
    @(negedge clk);
    br_done = 1'b0;
    checks++;
    if (imem_rd !== 1'b1 || imem_addr !== 8'h20) begin
      errors++;
      $display("FAIL br_taken: rd=%b addr=%h, required 1 20", imem_rd, imem_addr);
    end
    wait_valid(10, n);
    issue_ready = 1'b1;
    @(negedge clk);
    issue_ready = 1'b0;
    br_done = 1'b1; br_taken = 1'b1; br_target = 8'hFF;
    wait_valid(10, n);
    checks++;
    if (pc !== 8'hFF || {op, rs, rt, imm} !== 8'h46) begin
      errors++;
      $display("FAIL wrap_issue: pc=%h instr=%h, required ff 46", pc, {op, rs, rt, imm});
    end
    issue_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_rd !== 1'b1 || imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL pc_wrap: rd=%b addr=%h, required 1 00", imem_rd, imem_addr);
    end
    go_idle();

    run_to_pc4();
    issue_ready = 1'b1;
    @(negedge clk);
    issue_ready = 1'b0;
    br_done = 1'b1; br_taken = 1'b0; br_target = 8'h20;
    @(negedge clk);
    br_done = 1'b0;
    checks++;
    if (imem_rd !== 1'b1 || imem_addr !== 8'h05) begin
      errors++;
      $display("FAIL br_not_taken: rd=%b addr=%h, required 1 05", imem_rd, imem_addr);
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    run_to_pc4();
    issue_ready = 1'b1;
    @(negedge clk);
    issue_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, issue_valid, imem_rd} !== 3'b000 || pc !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: busy/valid/rd=%b pc=%h, required 000 00",
               {busy, issue_valid, imem_rd}, pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: busy=%b valid=%b, required 0 0", busy, issue_valid);
    end
  endtask

  // Reference model: walk the program in mem from pc 0; each accepted
  // instruction advances pc by one, except branches which take the
  // resolution supplied by the bench.
  task automatic test_random();
    logic [7:0] model_pc;
    logic [7:0] instr;
    int n;
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    model_pc = 8'h00;
    issue_ready = 1'b0;
    start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      wait_valid(20, n);
      instr = mem[model_pc];
      checks++;
      if (pc !== model_pc || {op, rs, rt, imm} !== instr) begin
        errors++;
        $display("FAIL rand_issue[%0d]: pc=%h instr=%h, required pc=%h instr=%h",
                 k, pc, {op, rs, rt, imm}, model_pc, instr);
      end
      for (int s = 0; s < 6; s++) begin
        if ($urandom_range(0, 2) != 0) break;
        issue_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (issue_valid !== 1'b1 || {op, rs, rt, imm} !== instr) begin
          errors++;
          $display("FAIL rand_stall[%0d]: valid=%b instr=%h, required 1 %h",
                   k, issue_valid, {op, rs, rt, imm}, instr);
        end
      end
      issue_ready = 1'b1;
      if (instr[7:6] == 2'b11) begin
        @(negedge clk);
        issue_ready = 1'b0;
        repeat ($urandom_range(0, 3)) begin
          checks++;
          if (issue_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rand_br_wait[%0d]: valid=%b busy=%b, required 0 1", k, issue_valid, busy);
          end
          @(negedge clk);
        end
        br_taken  = 1'($urandom);
        br_target = 8'($urandom);
        br_done   = 1'b1;
        model_pc  = br_taken ? br_target : model_pc + 8'd1;
      end else begin
        model_pc = model_pc + 8'd1;
      end
    end
    go_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    test_reset();
    test_sequence_and_halt();
    test_stall();
    test_branch_and_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
